// File: rtl/bus_select_arbiter_if.sv
// -----------------------------------------------------------------------------
// bus_select_arbiter_if
// Purpose : Groups the requester handshakes, the decoder PROM interface and the
//           device selects of bus_select_arbiter into a single bundle.
// Signals :
//   m_req/m_addr/m_ack   main requester request, address and completion pulse
//   s_req/s_addr/s_ack   sub requester request, address and completion pulse
//   err                  invalid-decode pulse, coincident with the ack
//   grant_sub            owner of the current/last transaction (1 = sub)
//   dec_addr/dec_cs_n    registered address and chip select to the decoder
//   dec_sel              registered active-low select returned by the decoder
//   dev_cs_n             registered active-low device selects to the bus
// Modports:
//   master  arbiter side (drives acks, decoder address/select, device selects)
//   slave   environment side (requesters and decoder PROM)
// -----------------------------------------------------------------------------
interface bus_select_arbiter_if;
   logic       m_req;
   logic [8:0] m_addr;
   logic       m_ack;
   logic       s_req;
   logic [8:0] s_addr;
   logic       s_ack;
   logic       err;
   logic       grant_sub;
   logic [8:0] dec_addr;
   logic       dec_cs_n;
   logic [3:0] dec_sel;
   logic [3:0] dev_cs_n;

   modport master (
      input  m_req, m_addr, s_req, s_addr, dec_sel,
      output m_ack, s_ack, err, grant_sub, dec_addr, dec_cs_n, dev_cs_n
   );

   modport slave (
      output m_req, m_addr, s_req, s_addr, dec_sel,
      input  m_ack, s_ack, err, grant_sub, dec_addr, dec_cs_n, dev_cs_n
   );
endinterface

// File: rtl/bus_select_arbiter.sv
// -----------------------------------------------------------------------------
// bus_select_arbiter
// Purpose : Two-requester (main CPU / sub CPU) bus sequencer in front of the
//           memory-map select decoder PROM. Grants one requester (round robin
//           on a tie), drives the decoder address and chip select, waits out
//           the decoder's registered latency, asserts the decoded device
//           select for WAITn+1 cycles, then returns a one-cycle ack (plus err
//           when the address decodes to no region or to several regions).
// Ports   :
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    bus_select_arbiter_if.master (requesters, decoder, device selects)
// Params  :
//   WAIT0..WAIT3  extra wait cycles for regions 0..3 (0..7)
// -----------------------------------------------------------------------------
module bus_select_arbiter #(
   parameter logic [2:0] WAIT0 = 3'd0,
   parameter logic [2:0] WAIT1 = 3'd1,
   parameter logic [2:0] WAIT2 = 3'd2,
   parameter logic [2:0] WAIT3 = 3'd3
) (
   input  logic                  clk,
   input  logic                  reset,
   bus_select_arbiter_if.master  bus
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_DECODE = 3'd1;
   localparam logic [2:0] ST_SAMPLE = 3'd2;
   localparam logic [2:0] ST_ACCESS = 3'd3;
   localparam logic [2:0] ST_DONE   = 3'd4;

   logic [2:0] r_state;
   logic [2:0] r_cnt;
   logic       r_err;
   logic       r_prio_sub;   // 1 = sub wins the next tie

   logic       w_any_req;
   logic       w_grant_sub;
   logic [3:0] w_sel_act;
   logic       w_sel_onehot;
   logic [2:0] w_wait;

   assign w_any_req   = bus.m_req | bus.s_req;
   assign w_grant_sub = (bus.m_req & bus.s_req) ? r_prio_sub : bus.s_req;

   // Exactly one select low <=> the inverted select is a non-zero power of two.
   assign w_sel_act    = ~bus.dec_sel;
   assign w_sel_onehot = (w_sel_act != 4'd0) &&
                         ((w_sel_act & (w_sel_act - 4'd1)) == 4'd0);

   // NOTE: every always_comb output gets a default first so no path can
   // leave it unassigned and infer a latch.
   always_comb begin
      w_wait = 3'd0;
      case (bus.dec_sel)
         4'he:    w_wait = WAIT0;
         4'hd:    w_wait = WAIT1;
         4'hb:    w_wait = WAIT2;
         4'h7:    w_wait = WAIT3;
         default: w_wait = 3'd0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state       <= ST_IDLE;
         r_cnt         <= 3'd0;
         r_err         <= 1'b0;
         r_prio_sub    <= 1'b0;
         bus.m_ack     <= 1'b0;
         bus.s_ack     <= 1'b0;
         bus.err       <= 1'b0;
         bus.grant_sub <= 1'b0;
         bus.dec_addr  <= 9'd0;
         bus.dec_cs_n  <= 1'b1;
         bus.dev_cs_n  <= 4'hf;
      end else begin
         // Acks and err are single-cycle pulses: cleared every cycle unless
         // the ACCESS completion below sets them.
         bus.m_ack <= 1'b0;
         bus.s_ack <= 1'b0;
         bus.err   <= 1'b0;

         case (r_state)
            ST_IDLE: begin
               if (w_any_req) begin
                  bus.grant_sub <= w_grant_sub;
                  bus.dec_addr  <= w_grant_sub ? bus.s_addr : bus.m_addr;
                  bus.dec_cs_n  <= 1'b0;
                  r_prio_sub    <= ~w_grant_sub;
                  r_state       <= ST_DECODE;
               end
            end

            // Decoder registers its select on this edge.
            ST_DECODE: r_state <= ST_SAMPLE;

            ST_SAMPLE: begin
               if (w_sel_onehot) begin
                  bus.dev_cs_n <= bus.dec_sel;
                  r_cnt        <= w_wait;
                  r_err        <= 1'b0;
               end else begin
                  bus.dev_cs_n <= 4'hf;
                  r_cnt        <= 3'd0;
                  r_err        <= 1'b1;
               end
               r_state <= ST_ACCESS;
            end

            ST_ACCESS: begin
               if (r_cnt != 3'd0) begin
                  r_cnt <= r_cnt - 3'd1;
               end else begin
                  bus.dev_cs_n <= 4'hf;
                  bus.dec_cs_n <= 1'b1;
                  bus.m_ack    <= ~bus.grant_sub;
                  bus.s_ack    <= bus.grant_sub;
                  bus.err      <= r_err;
                  r_state      <= ST_DONE;
               end
            end

            ST_DONE: r_state <= ST_IDLE;

            default: r_state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_bus_select_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_select_arbiter
// Purpose : Directed self-checking bench for bus_select_arbiter with a
//           registered decoder PROM model. Inputs change and outputs are
//           sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_bus_select_arbiter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   always #5 clk = ~clk;

   bus_select_arbiter_if bus_if ();

   bus_select_arbiter #(
      .WAIT0(3'd0), .WAIT1(3'd1), .WAIT2(3'd2), .WAIT3(3'd3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_if)
   );

   int tests_run = 0;
   int fails     = 0;

   // Decoder PROM model: addr[8:6] picks the region; override for bad decodes.
   logic       force_en  = 1'b0;
   logic [3:0] force_val = 4'hf;

   function automatic logic [3:0] prom(input logic [8:0] a);
      case (a[8:6])
         3'd0:    return 4'h7;   // 9'h000 -> region 3
         3'd1:    return 4'he;   // 9'h040 -> region 0
         3'd2:    return 4'hd;   // 9'h080 -> region 1
         3'd4:    return 4'hb;   // 9'h100 -> region 2
         default: return 4'hf;
      endcase
   endfunction

   always @(posedge clk)
      bus_if.dec_sel <= bus_if.dec_cs_n ? 4'hf :
                        (force_en ? force_val : prom(bus_if.dec_addr));

   task automatic check(input string tag, input logic [15:0] obs,
                        input logic [15:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
         $error("check %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Starts at a falling edge with the DUT idle and the request(s) driven;
   // ends at the falling edge after the DONE cycle.
   task automatic observe_txn(input string tag, input bit sub,
                              input logic [8:0] addr, input logic [3:0] exp_dev,
                              input int len, input bit exp_err,
                              input bit drop_at_ack, input bit drop_after_grant);
      step();  // after grant edge E0
      check({tag, ".cs_grant"}, bus_if.dec_cs_n, 1'b0);
      check({tag, ".addr"},     bus_if.dec_addr, addr);
      check({tag, ".gsub"},     bus_if.grant_sub, sub);
      check({tag, ".ack_e0"},   {bus_if.m_ack, bus_if.s_ack}, 2'b00);
      if (drop_after_grant) begin
         // Dropping the request and moving the address must not matter.
         if (sub) begin bus_if.s_req = 1'b0; bus_if.s_addr = 9'h1ff; end
         else     begin bus_if.m_req = 1'b0; bus_if.m_addr = 9'h1ff; end
      end
      step();  // after E1
      check({tag, ".dev_e1"}, bus_if.dev_cs_n, 4'hf);
      for (int i = 0; i < len; i++) begin
         step();
         check({tag, ".dev_on"}, bus_if.dev_cs_n, exp_dev);
         check({tag, ".ack_wait"}, {bus_if.m_ack, bus_if.s_ack, bus_if.err}, 3'b000);
      end
      step();  // ack cycle
      check({tag, ".dev_off"}, bus_if.dev_cs_n, 4'hf);
      check({tag, ".cs_off"},  bus_if.dec_cs_n, 1'b1);
      check({tag, ".acks"},    {bus_if.m_ack, bus_if.s_ack}, {~sub, sub});
      check({tag, ".err"},     bus_if.err, exp_err);
      if (drop_at_ack) begin
         if (sub) bus_if.s_req = 1'b0;
         else     bus_if.m_req = 1'b0;
      end
      step();  // DONE cycle
      check({tag, ".ack_done"}, {bus_if.m_ack, bus_if.s_ack, bus_if.err}, 3'b000);
   endtask

   initial begin
      // Both requests held from reset: alternation main, sub, main, sub.
      bus_if.m_req  = 1'b1;
      bus_if.m_addr = 9'h000;
      bus_if.s_req  = 1'b1;
      bus_if.s_addr = 9'h080;
      step();
      check("rst.acks", {bus_if.m_ack, bus_if.s_ack, bus_if.err}, 3'b000);
      check("rst.gsub", bus_if.grant_sub, 1'b0);
      check("rst.addr", bus_if.dec_addr, 9'h000);
      check("rst.cs",   bus_if.dec_cs_n, 1'b1);
      check("rst.dev",  bus_if.dev_cs_n, 4'hf);
      reset = 1'b0;
      observe_txn("rr1_main", 1'b0, 9'h000, 4'h7, 4, 1'b0, 1'b0, 1'b0);
      observe_txn("rr2_sub",  1'b1, 9'h080, 4'hd, 2, 1'b0, 1'b0, 1'b0);
      observe_txn("rr3_main", 1'b0, 9'h000, 4'h7, 4, 1'b0, 1'b1, 1'b0);
      observe_txn("rr4_sub",  1'b1, 9'h080, 4'hd, 2, 1'b0, 1'b1, 1'b0);
      step();
      check("rr.idle_cs", bus_if.dec_cs_n, 1'b1);

      // Main only, region 0.
      bus_if.m_req  = 1'b1;
      bus_if.m_addr = 9'h040;
      observe_txn("main_r0", 1'b0, 9'h040, 4'he, 1, 1'b0, 1'b1, 1'b0);

      // Sub only, region 2 (also sub granted right after main: single requester).
      bus_if.s_req  = 1'b1;
      bus_if.s_addr = 9'h100;
      observe_txn("sub_r2", 1'b1, 9'h100, 4'hb, 3, 1'b0, 1'b1, 1'b0);

      // Invalid decodes: none low, several low, all low.
      force_en  = 1'b1;
      force_val = 4'hf;
      bus_if.m_req  = 1'b1;
      bus_if.m_addr = 9'h040;
      observe_txn("bad_f", 1'b0, 9'h040, 4'hf, 1, 1'b1, 1'b1, 1'b0);
      force_val = 4'h3;
      bus_if.m_req = 1'b1;
      observe_txn("bad_3", 1'b0, 9'h040, 4'hf, 1, 1'b1, 1'b1, 1'b0);
      force_val = 4'h0;
      bus_if.s_req  = 1'b1;
      bus_if.s_addr = 9'h040;
      observe_txn("bad_0", 1'b1, 9'h040, 4'hf, 1, 1'b1, 1'b1, 1'b0);
      force_en = 1'b0;

      // Reset in the middle of a region 3 access.
      bus_if.m_req  = 1'b1;
      bus_if.m_addr = 9'h000;
      step();  // E0
      step();  // E1
      step();  // E2
      check("mid.dev_on", bus_if.dev_cs_n, 4'h7);
      step();  // E3, still in ACCESS
      reset = 1'b1;
      #1;
      check("mid.dev",  bus_if.dev_cs_n, 4'hf);
      check("mid.cs",   bus_if.dec_cs_n, 1'b1);
      check("mid.acks", {bus_if.m_ack, bus_if.s_ack, bus_if.err}, 3'b000);
      check("mid.gsub", bus_if.grant_sub, 1'b0);
      check("mid.addr", bus_if.dec_addr, 9'h000);
      bus_if.m_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         check("mid.hold_acks", {bus_if.m_ack, bus_if.s_ack, bus_if.err}, 3'b000);
         check("mid.hold_dev", bus_if.dev_cs_n, 4'hf);
      end
      reset = 1'b0;
      step();
      check("post.acks", {bus_if.m_ack, bus_if.s_ack, bus_if.err}, 3'b000);
      check("post.cs",   bus_if.dec_cs_n, 1'b1);
      bus_if.m_req  = 1'b1;
      bus_if.m_addr = 9'h000;
      observe_txn("post_r3", 1'b0, 9'h000, 4'h7, 4, 1'b0, 1'b1, 1'b0);

      // Main drops request one cycle after grant: still completes, no regrant.
      bus_if.m_req  = 1'b1;
      bus_if.m_addr = 9'h100;
      observe_txn("drop", 1'b0, 9'h100, 4'hb, 3, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step();
         check("drop.no_regrant", bus_if.dec_cs_n, 1'b1);
         check("drop.no_ack", {bus_if.m_ack, bus_if.s_ack}, 2'b00);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, fails);
      $finish;
   end

endmodule

// File: doc/bus_select_arbiter.md
Name: bus_select_arbiter

Overview:
Two-requester bus sequencer sitting in front of the 9-bit-address / 4-bit active-low select decoder PROM used for the memory map. It arbitrates between the main CPU and the sub CPU port and drives the decoder's address and chip select. It waits out the decoder's one-cycle registered latency, then asserts the decoded device select for a per-region number of wait cycles. It returns a one-cycle acknowledge to the granted requester, plus an error flag when the address decodes to no region.

Parameters:
WAIT0, 0, extra wait cycles for region 0 (dec_sel = 4'he, bit0 low)
WAIT1, 1, extra wait cycles for region 1 (dec_sel = 4'hd, bit1 low)
WAIT2, 2, extra wait cycles for region 2 (dec_sel = 4'hb, bit2 low)
WAIT3, 3, extra wait cycles for region 3 (dec_sel = 4'h7, bit3 low)
(each 0..7; wait counter is 3 bits)

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-high reset
m_req  in  1  main requester access request (level)
m_addr  in  9  main requester address
m_ack  out  1  one-cycle completion pulse to main
s_req  in  1  sub requester access request (level)
s_addr  in  9  sub requester address
s_ack  out  1  one-cycle completion pulse to sub
err  out  1  one-cycle pulse, coincident with the ack, when the decode is invalid
grant_sub  out  1  0 = main owns the current/last transaction, 1 = sub
dec_addr  out  9  registered address to the decoder
dec_cs_n  out  1  registered active-low chip select to the decoder
dec_sel  in  4  registered active-low select returned by the decoder (valid one clock after dec_cs_n sampled low)
dev_cs_n  out  4  registered active-low device selects to the bus

Behaviour:
- Reset values (async, immediate): m_ack=0, s_ack=0, err=0, grant_sub=0, dec_addr=0, dec_cs_n=1, dev_cs_n=4'hf, state=IDLE, wait counter=0, round-robin pointer set so main wins the first tie.
- States: IDLE, DECODE, SAMPLE, ACCESS, DONE.
- IDLE, edge E0: if any req is high, grant it.
  - If both are high, grant the one not granted last (round robin).
  - Latch the granted address into dec_addr, set dec_cs_n<=0, set grant_sub, go to DECODE.
  - If no req is high, stay in IDLE.
- DECODE (E1): the decoder samples the select. Go to SAMPLE.
- SAMPLE (E2): read dec_sel.
  - Exactly one bit low: dev_cs_n<=dec_sel, counter<=WAITn for that region, go to ACCESS.
  - Otherwise (4'hf, 4'h0, or several bits low): dev_cs_n stays 4'hf, flag the error internally, counter<=0, go to ACCESS.
- ACCESS: on each edge, if counter≠0 then decrement it. If counter==0 then:
  - dev_cs_n<=4'hf, dec_cs_n<=1;
  - pulse the granted ack<=1, and err<=1 if an error was flagged;
  - go to DONE.
- DONE: acks and err <=0, go to IDLE. A new grant is possible on the next edge.
- Timing: dev_cs_n is low for exactly WAITn+1 cycles. The ack is high in the cycle after E(3+WAITn), where E0 is the grant edge. Minimum turnaround from grant to next grant is 5 cycles.
- The requester holds req until it sees its ack, then drops it. The address is latched at grant, so later changes are ignored.
- Dropping req before ack does not abort: the transaction completes and the ack still pulses.
- The round-robin pointer updates only at grant. A single requester may be granted repeatedly when the other is idle.
- Only one ack is ever high at a time. m_ack and s_ack are never high together.
- Reset asserted in any state returns every output to its reset value at once. Deasserting reset resumes in IDLE, with no stale ack or err.

Test Plan:
- Main only, m_addr=9'h040, decoder returns 4'he: dec_cs_n low from E0; dev_cs_n=4'he for 1 cycle; m_ack pulses once after E3; err=0; s_ack stays 0.
- Sub only, s_addr=9'h100, decoder returns 4'hb: dev_cs_n=4'hb for exactly 3 cycles; s_ack after E5; grant_sub=1.
- Both requests held from reset, addresses 9'h000 and 9'h080: grants alternate main, sub, main, sub. Checks are dev_cs_n=4'h7 for 4 cycles on main turns and 4'hd for 2 cycles on sub turns, with no overlapping acks.
- Decoder model forced to 4'hf (and separately 4'h3): dev_cs_n stays 4'hf; ack and err pulse together after E3.
- Reset pulsed mid-ACCESS on a region 3 access: dev_cs_n=4'hf, dec_cs_n=1, no ack during reset. A fresh m_req afterwards completes normally.
- m_req dropped one cycle after grant: m_ack still pulses once; no new grant follows.
